// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-outstanding APB requester with PREADY wait timeout
module apb_initiator #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_prot,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic          r_psel;
  logic          r_penable;
  logic [31:0]   r_paddr;
  logic [2:0]    r_pprot;
  logic          r_pwrite;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_pstrb;
  logic [CW-1:0] w_wait_next;

  // Wait count after the current non-ready ACCESS cycle; reaching TIMEOUT aborts.
  assign w_wait_next = r_wait + 1'b1;

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pprot      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_paddr     <= req_addr;
            r_pwrite    <= req_write;
            r_pwdata    <= req_wdata;
            r_pprot     <= req_prot;
            r_pstrb     <= req_write ? req_wstrb : 4'b0000;
            r_req_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_wait    <= '0;
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready responder wins even on the last allowed cycle.
          if (out_pready) begin
            r_resp_rdata <= r_pwrite ? 32'h0 : out_prdata;
            r_resp_err   <= out_pslverr;
            r_resp_valid <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_wait <= w_wait_next;
            if (w_wait_next == CW'(TIMEOUT)) begin
              r_resp_rdata <= 32'h0;
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
              r_psel       <= 1'b0;
              r_penable    <= 1'b0;
              r_state      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign out_paddr   = r_paddr;
  assign out_psel    = r_psel;
  assign out_penable = r_penable;
  assign out_pprot   = r_pprot;
  assign out_pwrite  = r_pwrite;
  assign out_pwdata  = r_pwdata;
  assign out_pstrb   = r_pstrb;

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - randomized self-checking bench for apb_initiator
module tb_apb_initiator;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;

  int errors = 0;
  int checks = 0;

  apb_initiator #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  // One full transaction. The responder stays not-ready for nwait ACCESS cycles
  // (asserting a bogus pslverr meanwhile) and is ready on the next; the response
  // is back-pressured for hold cycles. Expectations come from the rules:
  // completion edge = 2 + nwait, abort (nwait >= T) edge = 1 + T.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] prot, input int nwait,
                         input logic [31:0] sdata, input logic serr, input int hold,
                         input logic keep_valid, input string name);
    logic        abort;
    int          exp_edge;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    int          lat;
    int          acc;
    logic        done;
    abort     = (nwait >= T);
    exp_edge  = abort ? (1 + T) : (2 + nwait);
    exp_rdata = (wr || abort) ? 32'h0 : sdata;
    exp_err   = abort ? 1'b1 : serr;
    exp_strb  = wr ? wstrb : 4'b0000;

    checks++;
    if (req_ready !== 1'b1 || out_psel !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: req_ready=%b psel=%b resp_valid=%b, required 1 0 0",
               name, req_ready, out_psel, resp_valid);
    end
    req_valid  = 1'b1;
    req_addr   = addr;
    req_write  = wr;
    req_wdata  = wdata;
    req_wstrb  = wstrb;
    req_prot   = prot;
    resp_ready = (hold == 0);
    out_pready = 1'b0;
    @(posedge clock);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < T + 6) begin
      @(negedge clock);
      lat++;
      if (!keep_valid) req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        checks++;
        if (out_psel !== 1'b1 || out_penable !== (lat > 1) || out_paddr !== addr ||
            out_pwrite !== wr || out_pwdata !== wdata || out_pstrb !== exp_strb ||
            out_pprot !== prot) begin
          errors++;
          $display("FAIL %s bus cycle %0d: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h pprot=%h, required 1 %b %h %b %h %h %h",
                   name, lat, out_psel, out_penable, out_paddr, out_pwrite, out_pwdata,
                   out_pstrb, out_pprot, (lat > 1), addr, wr, wdata, exp_strb, prot);
        end
        if (lat > 1) begin
          acc = lat - 1;
          if (acc == nwait + 1) begin
            out_pready  = 1'b1;
            out_prdata  = sdata;
            out_pslverr = serr;
          end else begin
            out_pready  = 1'b0;
            out_prdata  = $urandom;
            out_pslverr = 1'b1;
          end
        end
        @(posedge clock);
      end
    end
    out_pready  = 1'b0;
    out_pslverr = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s response timeout: resp_valid=%b after %0d cycles, required 1", name, resp_valid, lat);
    end
    checks++;
    if (lat - 1 != exp_edge) begin
      errors++;
      $display("FAIL %s latency: resp_valid at edge %0d, required %0d", name, lat - 1, exp_edge);
    end
    checks++;
    if (resp_rdata !== exp_rdata || resp_err !== exp_err || out_psel !== 1'b0 ||
        out_penable !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s response: rdata=%h err=%b psel=%b penable=%b req_ready=%b, required %h %b 0 0 0",
               name, resp_rdata, resp_err, out_psel, out_penable, req_ready, exp_rdata, exp_err);
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err ||
          out_psel !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold %0d: resp_valid=%b rdata=%h err=%b psel=%b req_ready=%b, required 1 %h %b 0 0",
                 name, i, resp_valid, resp_rdata, resp_err, out_psel, req_ready, exp_rdata, exp_err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || out_psel !== 1'b0 || out_paddr !== addr) begin
      errors++;
      $display("FAIL %s handshake: resp_valid=%b req_ready=%b psel=%b paddr=%h, required 0 1 0 %h",
               name, resp_valid, req_ready, out_psel, out_paddr, addr);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        out_psel !== 1'b0 || out_penable !== 1'b0 || out_paddr !== 32'h0 || out_pwdata !== 32'h0 ||
        out_pstrb !== 4'h0 || out_pprot !== 3'h0 || out_pwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req_ready=%b resp_valid=%b rdata=%h err=%b psel=%b penable=%b paddr=%h pwdata=%h pstrb=%h pprot=%h pwrite=%b, required 1 0 0 0 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, out_psel, out_penable, out_paddr,
               out_pwdata, out_pstrb, out_pprot, out_pwrite);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of an ACCESS phase.
    req_valid = 1'b1; req_addr = 32'h1000_2000; req_write = 1'b1;
    req_wdata = 32'h0000_5A5A; req_wstrb = 4'hF; req_prot = 3'h0;
    out_pready = 1'b0; resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (out_psel !== 1'b1 || out_penable !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup_access: psel=%b penable=%b, required 1 1", out_psel, out_penable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_psel !== 1'b0 || out_penable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_access: psel=%b penable=%b resp_valid=%b req_ready=%b, required 0 0 0 1",
               out_psel, out_penable, resp_valid, req_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || out_psel !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_response cycle %0d: resp_valid=%b req_ready=%b psel=%b, required 0 1 0",
                 i, resp_valid, req_ready, out_psel);
      end
    end
  endtask

  task automatic test_zero_wait_write();
    run_txn(32'h1000_2000, 1'b1, 32'h0000_A5A5, 4'hF, 3'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, "zero_wait_write");
  endtask

  task automatic test_wait_read();
    run_txn(32'h1000_2004, 1'b0, 32'h1111_2222, 4'hF, 3'h2, 3, 32'h0000_1234, 1'b0, 0, 1'b0, "read_3_waits");
  endtask

  task automatic test_slave_error();
    run_txn(32'h1000_200C, 1'b1, 32'h0000_00FF, 4'h3, 3'h1, 0, 32'h0, 1'b1, 0, 1'b0, "slverr_write");
    run_txn(32'h1000_200C, 1'b1, 32'h0000_00FF, 4'h3, 3'h1, 2, 32'h0, 1'b0, 0, 1'b0, "slverr_while_not_ready");
  endtask

  task automatic test_timeout();
    run_txn(32'h1000_2010, 1'b0, 32'h0, 4'h0, 3'h0, T, 32'hCAFE_F00D, 1'b0, 0, 1'b0, "timeout_abort");
    run_txn(32'h1000_2010, 1'b0, 32'h0, 4'h0, 3'h0, T - 1, 32'hCAFE_F00D, 1'b0, 0, 1'b0, "ready_on_last_cycle");
  endtask

  task automatic test_back_to_back();
    run_txn(32'h1000_2020, 1'b0, 32'h0, 4'h0, 3'h4, 1, 32'h8765_4321, 1'b0, 5, 1'b1, "backpressure_first");
    run_txn(32'h1000_2024, 1'b1, 32'h0BAD_F00D, 4'h5, 3'h4, 0, 32'h0, 1'b0, 0, 1'b0, "backpressure_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, T + 1)), $urandom, 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
